// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 decoding definitions: prefix bytes, decoder states and
// the bit layout of a packed key event {ext, brk, code}.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Number of flag bits packed above the scan code in an event word.
  localparam int EVT_FLAG_W = 2;

  // Prefix-tracking states of the scan byte decoder.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  // Bit position of the ext flag in an event word of the given code width;
  // brk sits one bit below it, the code occupies the low bits.
  function automatic int evt_ext_bit(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int evt_brk_bit(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/ps2_key_event_decoder_fifo.sv
// Small event FIFO: push/pop with simultaneous push+pop allowed even when
// full, head word presented combinationally, and a drop strobe when a push
// is refused because there is no room.
module key_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk_Nexys,
  input  logic                     Reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign count   = count_reg;
  // Show zeros when nothing is stored so an empty head never leaks stale data.
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  // Storage write; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_Nexys) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_Nexys or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop_ok)      count_reg <= count_reg + 1'b1;
      else if (pop_ok && !push_ok) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 key event decoder: strips E0/F0 prefixes from the scan byte
// stream, filters typematic repeats of the held key, and queues complete
// {ext, brk, code} events for a valid/ready consumer.
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit FILTER_REP = 1'b1,
  parameter bit REPORT_BRK = 1'b1
) (
  input  logic                        clk_Nexys,
  input  logic                        Reset_n,
  input  logic [DATA_W-1:0]           byte_dato,
  input  logic                        scan_done_tick,
  input  logic                        evt_ready,
  output logic                        evt_valid,
  output logic [DATA_W-1:0]           evt_code,
  output logic                        evt_ext,
  output logic                        evt_brk,
  output logic [$clog2(FIFO_DEPTH):0] evt_count,
  output logic                        overflow
);

  localparam int EVT_W = DATA_W + EVT_FLAG_W;

  ps2_state_t        state_reg, state_next;
  logic              emit, emit_ext, emit_brk;
  logic              is_ext, is_brk;
  logic [DATA_W:0]   held_reg;
  logic              held_vld_reg;
  logic              held_match;
  logic              push;
  logic              fifo_empty, fifo_full, fifo_drop;
  logic [EVT_W-1:0]  head;
  logic              overflow_reg;

  assign is_ext = (byte_dato == DATA_W'(PS2_PREFIX_EXT));
  assign is_brk = (byte_dato == DATA_W'(PS2_PREFIX_BRK));

  // Prefix state register.
  always_ff @(posedge clk_Nexys or negedge Reset_n) begin
    if (!Reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Prefix tracking and event emission on each received byte.
  always_comb begin
    state_next = state_reg;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_brk   = 1'b0;
    if (scan_done_tick) begin
      case (state_reg)
        ST_IDLE: begin
          if (is_ext)      state_next = ST_EXT;
          else if (is_brk) state_next = ST_BRK;
          else             emit = 1'b1;
        end
        ST_EXT: begin
          if (is_brk)      state_next = ST_EXT_BRK;
          else if (is_ext) state_next = ST_EXT;
          else begin
            emit       = 1'b1;
            emit_ext   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          // A prefix after F0 is malformed: abandon the sequence silently.
          state_next = ST_IDLE;
          if (!is_ext && !is_brk) begin
            emit     = 1'b1;
            emit_brk = 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          if (!is_ext && !is_brk) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_brk = 1'b1;
          end
        end
      endcase
    end
  end

  assign held_match = held_vld_reg && (held_reg == {emit_ext, byte_dato});
  // Makes repeating the held key are typematic noise; breaks go only if reported.
  assign push = emit && (emit_brk ? REPORT_BRK : !(FILTER_REP && held_match));

  // Held-key tracking; updated on the filter decision even if the FIFO drops it.
  always_ff @(posedge clk_Nexys or negedge Reset_n) begin
    if (!Reset_n) begin
      held_reg     <= '0;
      held_vld_reg <= 1'b0;
    end else if (emit) begin
      if (!emit_brk && push) begin
        held_reg     <= {emit_ext, byte_dato};
        held_vld_reg <= 1'b1;
      end else if (emit_brk && held_match) begin
        held_vld_reg <= 1'b0;
      end
    end
  end

  key_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_Nexys (clk_Nexys),
    .Reset_n   (Reset_n),
    .push      (push),
    .pop       (evt_ready),
    .din       ({emit_ext, emit_brk, byte_dato}),
    .dout      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (evt_count),
    .drop      (fifo_drop)
  );

  // Sticky record that at least one event was lost to a full FIFO.
  always_ff @(posedge clk_Nexys or negedge Reset_n) begin
    if (!Reset_n)       overflow_reg <= 1'b0;
    else if (fifo_drop) overflow_reg <= 1'b1;
  end

  assign evt_valid = !fifo_empty;
  assign evt_ext   = head[evt_ext_bit(DATA_W)];
  assign evt_brk   = head[evt_brk_bit(DATA_W)];
  assign evt_code  = head[DATA_W-1:0];
  assign overflow  = overflow_reg;

endmodule
